pc_sequencer: RTL

//  Control FSM for the fetch-stage program counter.
//  - Each cycle drives the PC counter's enable and 2-bit next-PC select.
//  - Arbitrates between sequential fetch, EX-stage branch redirect, JALR redirect, stall and halt.
//  - Generates the IF/ID flush window after a redirect.
//  - Sits between the hazard unit / EX stage and the PC register.

---
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer signal bundle: hazard/EX-side controls in, PC-register controls and status out.
// The master modport is the hazard/EX side; the slave modport is the sequencer.
interface pc_sequencer_if;
    logic       start;
    logic       halt_req;
    logic       stall;
    logic       br_taken_EX;
    logic       jalr_EX;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       flush_IF;
    logic       flush_ID;
    logic       busy;
    logic       halted;

    modport master (
        output start, halt_req, stall, br_taken_EX, jalr_EX,
        input  pc_en, pc_sel, flush_IF, flush_ID, busy, halted
    );

    modport slave (
        input  start, halt_req, stall, br_taken_EX, jalr_EX,
        output pc_en, pc_sel, flush_IF, flush_ID, busy, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: arbitrates sequential fetch, branch/JALR redirect, stall and halt.
// Optional performance counters are enabled by defining PCSEQ_PERF_EN.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | after reset, PC frozen until start
//  ST_RUN   | normal fetch, redirects and halt requests accepted
//  ST_FLUSH | wrong-path bubbles after a redirect, IF/ID and ID/EX killed
//  ST_HALT  | fetch stopped, waiting for start
module pc_sequencer #(
    parameter int FLUSH_CYCLES = 2
`ifdef PCSEQ_PERF_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef PCSEQ_PERF_EN
    output logic [CNT_W-1:0]  o_redirect_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt,
`endif
    pc_sequencer_if.slave     bus
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
            $error("pc_sequencer: FLUSH_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JALR   = 2'b10;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     r_state;
    logic [3:0] r_flush_cnt;
    logic       r_halt_pend;

    state_t     w_next_state;
    logic       w_pc_en;
    logic [1:0] w_pc_sel;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_tc;
    logic       w_pend_set;
    logic       w_pend_clr;
    logic       w_redirect;
    logic       w_busy;

    assign w_cnt_tc = (r_flush_cnt == 4'd1);
    assign w_busy   = (r_state == ST_RUN) || (r_state == ST_FLUSH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_en      = 1'b0;
        w_pc_sel     = SEL_SEQ;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        w_redirect   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                end
            end

            ST_HALT: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                    w_pend_clr   = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.jalr_EX || bus.br_taken_EX) begin
                    // Redirect beats both stall and halt; a coincident halt is deferred past the flush.
                    w_redirect   = 1'b1;
                    w_pc_en      = 1'b1;
                    w_pc_sel     = bus.jalr_EX ? SEL_JALR : SEL_BRANCH;
                    w_cnt_load   = 1'b1;
                    w_pend_set   = bus.halt_req;
                    w_next_state = ST_FLUSH;
                end else if (bus.halt_req) begin
                    w_next_state = ST_HALT;
                end else if (!bus.stall) begin
                    w_pc_en = 1'b1;
                end
            end

            ST_FLUSH: begin
                w_pc_en    = !bus.stall;
                w_pend_set = bus.halt_req;
                if (!bus.stall) begin
                    w_cnt_dec = 1'b1;
                    // A halt request arriving on the last bubble is honoured immediately.
                    if (w_cnt_tc) begin
                        w_next_state = (r_halt_pend || bus.halt_req) ? ST_HALT : ST_RUN;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush_cnt <= 4'd0;
        end else if (w_cnt_load) begin
            r_flush_cnt <= FLUSH_LOAD;
        end else if (w_cnt_dec) begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_halt_pend <= 1'b0;
        end else if (w_pend_clr) begin
            r_halt_pend <= 1'b0;
        end else if (w_pend_set) begin
            r_halt_pend <= 1'b1;
        end
    end

    assign bus.pc_en    = w_pc_en;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.flush_IF = (r_state == ST_FLUSH);
    assign bus.flush_ID = (r_state == ST_FLUSH);
    assign bus.busy     = w_busy;
    assign bus.halted   = (r_state == ST_HALT);

`ifdef PCSEQ_PERF_EN
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            if (w_busy && bus.stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_redirect_cnt = r_redirect_cnt;
    assign o_stall_cnt    = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_redirect;
`endif

endmodule
